// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg -- shared definitions for the program counter with return-address
// stack (pc_ras) and its stack sub-module (ras_stack).
//   next_sel_e : which source feeds the next PC value
//   ptr_width  : pointer width for a stack of a given (power-of-two) depth
// ---------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_RET    = 3'd1,
        SEL_CALL   = 3'd2,
        SEL_JUMP   = 3'd3,
        SEL_BRANCH = 3'd4,
        SEL_INC    = 3'd5
    } next_sel_e;

    // A two-entry stack still needs one pointer bit, so clamp at 1.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack -- circular-buffer return-address stack.
// Optional build macro: PC_RAS_OVF_TRAP_EN
//   defined   : push on a full stack is dropped and err_o pulses
//   undefined : push on a full stack overwrites the oldest entry silently
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   push_i         push push_data_i
//   pop_i          pop the top entry (ignored and flagged when empty)
//   push_data_i    return address to store
//   top_data_o     current top entry (valid when not empty)
//   empty_o/full_o decoded from the registered count
//   err_o          registered one-cycle pulse on underflow / trapped overflow
// ---------------------------------------------------------------------------
module ras_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_data_i,
    output logic [ADDR_W-1:0] top_data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              err_o
);

    localparam int PTR_W = ptr_width(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;   // next slot to write; top entry is r_ptr-1
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic [PTR_W-1:0]  w_ptr_prev;
    logic              w_do_push;
    logic              w_do_pop;
    logic              w_err;

    assign w_ptr_prev = r_ptr - PTR_W'(1);
    assign empty_o    = (r_cnt == CNT_W'(0));
    assign full_o     = (r_cnt == CNT_W'(RAS_DEPTH));
    assign top_data_o = r_mem[w_ptr_prev];
    assign err_o      = r_err;
    assign w_do_pop   = pop_i && !empty_o;

`ifdef PC_RAS_OVF_TRAP_EN
    assign w_do_push = push_i && !full_o;
    assign w_err     = (pop_i && empty_o) || (push_i && full_o);
`else
    // When full, r_ptr already points at the oldest entry, so a plain push
    // overwrites it and the buffer keeps the newest RAS_DEPTH addresses.
    assign w_do_push = push_i;
    assign w_err     = pop_i && empty_o;
`endif

    // Entry storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_ptr] <= push_data_i;
        end
    end

    // Pointer, saturating count and error pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ptr <= PTR_W'(0);
            r_cnt <= CNT_W'(0);
            r_err <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_ptr <= r_ptr + PTR_W'(1);
                if (!full_o) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_do_pop) begin
                r_ptr <= w_ptr_prev;
                r_cnt <= r_cnt - CNT_W'(1);
            end
            r_err <= w_err;
        end
    end

endmodule

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras -- instruction-fetch program counter with return-address stack.
// Optional build macro: PC_RAS_OVF_TRAP_EN (overflow policy, see ras_stack).
// Request priority: stall > ret > call > jump > branch > increment.
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   stall_i           hold PC and stack
//   jump_i/jump_tgt_i absolute jump
//   branch_i          PC-relative branch by sign-extended displacement_i
//   call_i            push PC+1 then jump to jump_tgt_i
//   ret_i             pop return address into PC (PC+1 if stack empty)
//   addr_imem_o       registered PC
//   ras_empty_o/full  stack occupancy flags
//   ras_err_o         one-cycle error pulse
// ---------------------------------------------------------------------------
module pc_ras
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                DISP_W     = 8,
    parameter int                RAS_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic              branch_i,
    input  logic              call_i,
    input  logic              ret_i,
    input  logic [DISP_W-1:0] displacement_i,
    input  logic [ADDR_W-1:0] jump_tgt_i,
    output logic [ADDR_W-1:0] addr_imem_o,
    output logic              ras_empty_o,
    output logic              ras_full_o,
    output logic              ras_err_o
);

    logic [ADDR_W-1:0] r_pc;
    next_sel_e         w_sel;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_disp_ext;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_ras_top;

    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_disp_ext  = ADDR_W'($signed(displacement_i));
    assign addr_imem_o = r_pc;

    // Priority encode the control requests into a single source select.
    always_comb begin
        w_sel = SEL_INC;
        if (stall_i) begin
            w_sel = SEL_HOLD;
        end else if (ret_i) begin
            w_sel = SEL_RET;
        end else if (call_i) begin
            w_sel = SEL_CALL;
        end else if (jump_i) begin
            w_sel = SEL_JUMP;
        end else if (branch_i) begin
            w_sel = SEL_BRANCH;
        end else begin
            w_sel = SEL_INC;
        end
    end

    // Next-PC mux; a return on an empty stack just falls through to PC+1.
    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_sel)
            SEL_HOLD:   w_pc_next = r_pc;
            SEL_RET:    w_pc_next = ras_empty_o ? w_pc_inc : w_ras_top;
            SEL_CALL:   w_pc_next = jump_tgt_i;
            SEL_JUMP:   w_pc_next = jump_tgt_i;
            SEL_BRANCH: w_pc_next = r_pc + w_disp_ext;
            SEL_INC:    w_pc_next = w_pc_inc;
            default:    w_pc_next = w_pc_inc;
        endcase
    end

    // PC register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pc <= RESET_ADDR;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_sel == SEL_CALL),
        .pop_i       (w_sel == SEL_RET),
        .push_data_i (w_pc_inc),
        .top_data_o  (w_ras_top),
        .empty_o     (ras_empty_o),
        .full_o      (ras_full_o),
        .err_o       (ras_err_o)
    );

endmodule

// File: tb/tb_pc_ras.sv
module tb_pc_ras;

    localparam int          AW    = 16;
    localparam int          DW    = 8;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RA    = 16'h0100;

    logic          clk = 1'b0;
    logic          rst_n, stall, jump, branch, call, ret;
    logic [DW-1:0] disp;
    logic [AW-1:0] tgt;
    logic [AW-1:0] addr;
    logic          empty, full, err;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] m_pc;
    logic [15:0] m_q[$];
    logic        m_err;

    logic [15:0] saved;

    always #5 clk = ~clk;

    pc_ras #(
        .ADDR_W(AW), .DISP_W(DW), .RAS_DEPTH(DEPTH), .RESET_ADDR(RA)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .jump_i(jump),
        .branch_i(branch), .call_i(call), .ret_i(ret),
        .displacement_i(disp), .jump_tgt_i(tgt),
        .addr_imem_o(addr), .ras_empty_o(empty), .ras_full_o(full),
        .ras_err_o(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive requests, advance the model by the spec rules, compare.
    task automatic step(input logic r, input logic s, input logic rt, input logic cl,
                        input logic jp, input logic br, input logic [7:0] d,
                        input logic [15:0] t);
        rst_n = r; stall = s; ret = rt; call = cl; jump = jp; branch = br;
        disp = d; tgt = t;
        @(posedge clk);
        #1;
        m_err = 1'b0;
        if (!r) begin
            m_pc = RA;
            m_q.delete();
        end else if (s) begin
            m_pc = m_pc;
        end else if (rt) begin
            if (m_q.size() > 0) m_pc = m_q.pop_back();
            else begin
                m_pc  = m_pc + 16'd1;
                m_err = 1'b1;
            end
        end else if (cl) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_pc + 16'd1);
            else begin
`ifdef PC_RAS_OVF_TRAP_EN
                m_err = 1'b1;
`else
                void'(m_q.pop_front());
                m_q.push_back(m_pc + 16'd1);
`endif
            end
            m_pc = t;
        end else if (jp) begin
            m_pc = t;
        end else if (br) begin
            m_pc = m_pc + {{8{d[7]}}, d};
        end else begin
            m_pc = m_pc + 16'd1;
        end
        check("addr",  32'(addr),  32'(m_pc));
        check("empty", 32'(empty), 32'(m_q.size() == 0));
        check("full",  32'(full),  32'(m_q.size() == DEPTH));
        check("err",   32'(err),   32'(m_err));
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    task automatic do_jump(input logic [15:0] t);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, t);
    endtask

    task automatic do_call(input logic [15:0] t);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, t);
    endtask

    task automatic do_ret();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0;
        call = 1'b0; ret = 1'b0; disp = 8'h00; tgt = 16'h0000;
        m_pc = 16'h0000; m_err = 1'b0;

        // reset and increment
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        check("reset_addr", 32'(addr), 32'h0100);
        check("reset_empty", 32'(empty), 32'h1);
        idle();
        check("inc1", 32'(addr), 32'h0101);
        idle();
        check("inc2", 32'(addr), 32'h0102);

        // negative branch to zero, increment wrap
        do_jump(16'h0010);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 16'h0000);
        check("branch_neg", 32'(addr), 32'h0000);
        do_jump(16'hFFFF);
        idle();
        check("inc_wrap", 32'(addr), 32'h0000);

        // call / return
        do_jump(16'h0020);
        do_call(16'h0400);
        check("call_tgt", 32'(addr), 32'h0400);
        check("call_nonempty", 32'(empty), 32'h0);
        idle(); idle(); idle();
        do_ret();
        check("ret_addr", 32'(addr), 32'h0021);
        check("ret_empty", 32'(empty), 32'h1);

        // nested calls to depth 4 then a fifth
        do_jump(16'h0100);
        do_call(16'h0200);
        do_call(16'h0300);
        do_call(16'h0400);
        do_call(16'h0500);
        check("nest_full", 32'(full), 32'h1);
        do_call(16'h0600);
`ifdef PC_RAS_OVF_TRAP_EN
        check("ovf_err", 32'(err), 32'h1);
        do_ret(); check("nret1", 32'(addr), 32'h0401);
        do_ret(); check("nret2", 32'(addr), 32'h0301);
        do_ret(); check("nret3", 32'(addr), 32'h0201);
        do_ret(); check("nret4", 32'(addr), 32'h0101);
`else
        check("ovf_noerr", 32'(err), 32'h0);
        do_ret(); check("nret1", 32'(addr), 32'h0501);
        do_ret(); check("nret2", 32'(addr), 32'h0401);
        do_ret(); check("nret3", 32'(addr), 32'h0301);
        do_ret(); check("nret4", 32'(addr), 32'h0201);
`endif
        check("nest_empty", 32'(empty), 32'h1);

        // underflow
        do_jump(16'h0050);
        do_ret();
        check("udf_addr", 32'(addr), 32'h0051);
        check("udf_err", 32'(err), 32'h1);
        idle();
        check("udf_err_clear", 32'(err), 32'h0);

        // stall beats call
        saved = addr;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0700);
        check("stall_addr", 32'(addr), 32'(saved));
        check("stall_empty", 32'(empty), 32'h1);

        // ret beats jump
        saved = addr + 16'd1;
        do_call(16'h0700);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0900);
        check("ret_over_jump", 32'(addr), 32'(saved));

        // reset during a call
        do_call(16'h0800);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0A00);
        check("rst_call_addr", 32'(addr), 32'h0100);
        check("rst_call_empty", 32'(empty), 32'h1);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic       r_r, r_s, r_rt, r_cl, r_jp, r_br;
            int         pick;
            r_r  = ($urandom_range(0, 99) >= 2);
            r_s  = ($urandom_range(0, 9) == 0);
            pick = $urandom_range(0, 99);
            r_rt = (pick < 25);
            r_cl = (pick >= 20 && pick < 50);
            r_jp = (pick >= 45 && pick < 60) || ($urandom_range(0, 9) == 0);
            r_br = (pick >= 55 && pick < 75) || ($urandom_range(0, 9) == 0);
            step(r_r, r_s, r_rt, r_cl, r_jp, r_br,
                 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
